// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO: read-mode encodings
// and the width of the pointer / fill-level vectors.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int fill_width(input int address_size);
    return address_size + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, status and threshold signals of the FIFO grouped into one bundle.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_if #(
  parameter int address_size = 4,
  parameter int data_size    = 8
);
  import sync_fifo_pkg::*;

  localparam int FW = fill_width(address_size);

  logic                 write_incr;
  logic [data_size-1:0] write_data;
  logic                 read_incr;
  logic [data_size-1:0] read_data;
  logic                 write_full;
  logic                 read_empty;
  logic [FW-1:0]        fill_level;
  logic [FW-1:0]        af_threshold;
  logic [FW-1:0]        ae_threshold;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;
  logic                 clear_flags;

  modport master (
    output write_incr, write_data, read_incr, af_threshold, ae_threshold, clear_flags,
    input  read_data, write_full, read_empty, fill_level, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  write_incr, write_data, read_incr, af_threshold, ae_threshold, clear_flags,
    output read_data, write_full, read_empty, fill_level, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: depth x data_size array, one clocked write port and one
// asynchronous read port.
module sync_fifo_mem #(
  parameter int address_size = 4,
  parameter int data_size    = 8
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [address_size-1:0] i_wr_addr,
  input  logic [data_size-1:0]    i_wr_data,
  input  logic [address_size-1:0] i_rd_addr,
  output logic [data_size-1:0]    o_rd_data
);

  localparam int DEPTH = 2 ** address_size;

  logic [data_size-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; emptiness is tracked by the pointers, so
  // stale contents are never observable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy decode, sticky error flags and the
// read path (registered or first-word-fall-through) around sync_fifo_mem.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int address_size = 4,
  parameter int data_size    = 8,
  parameter int fwft         = FIFO_STD
) (
  input  logic      clk,
  input  logic      reset_n,
  sync_fifo_if.slave bus
);

  localparam int PW    = fill_width(address_size);
  localparam int DEPTH = 2 ** address_size;

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic                 r_overflow;
  logic                 r_underflow;
  logic [PW-1:0]        w_fill;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [data_size-1:0] w_mem_rdata;

  // Modulo subtraction of the extended pointers gives occupancy 0..DEPTH.
  assign w_fill   = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_fill == PW'(DEPTH));
  assign w_empty  = (w_fill == '0);
  assign w_wr_acc = bus.write_incr && !w_full;
  assign w_rd_acc = bus.read_incr && !w_empty;

  assign bus.fill_level   = w_fill;
  assign bus.write_full   = w_full;
  assign bus.read_empty   = w_empty;
  assign bus.almost_full  = (w_fill >= bus.af_threshold);
  assign bus.almost_empty = (w_fill <= bus.ae_threshold);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Setting takes priority over clear_flags on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.write_incr && w_full) r_overflow <= 1'b1;
      else if (bus.clear_flags)     r_overflow <= 1'b0;
      if (bus.read_incr && w_empty) r_underflow <= 1'b1;
      else if (bus.clear_flags)     r_underflow <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .address_size (address_size),
    .data_size    (data_size)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[address_size-1:0]),
    .i_wr_data (bus.write_data),
    .i_rd_addr (r_rd_ptr[address_size-1:0]),
    .o_rd_data (w_mem_rdata)
  );

  generate
    if (fwft == FIFO_FWFT) begin : g_fwft
      // Head word is shown combinationally; forced to 0 while empty so the
      // output is defined during and right after reset.
      assign bus.read_data = w_empty ? '0 : w_mem_rdata;
    end else begin : g_std
      logic [data_size-1:0] r_read_data;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_read_data <= '0;
        else if (w_rd_acc) r_read_data <= w_mem_rdata;
      end

      assign bus.read_data = r_read_data;
    end
  endgenerate

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter address_size, default 4, meaning log2 of depth; depth = 2**address_size entries.
REQ-002 SHALL have parameter data_size, default 8, meaning word width in bits.
REQ-003 SHALL have parameter fwft, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port write_incr, input, 1 bit: write request.
REQ-007 SHALL have port write_data, input, data_size bits: write word.
REQ-008 SHALL have port read_incr, input, 1 bit: read request.
REQ-009 SHALL have port read_data, output, data_size bits: read word.
REQ-010 SHALL have port write_full, output, 1 bit: fill_level == depth.
REQ-011 SHALL have port read_empty, output, 1 bit: fill_level == 0.
REQ-012 SHALL have port fill_level, output, address_size+1 bits: current occupancy, 0..depth.
REQ-013 SHALL have port af_threshold, input, address_size+1 bits: almost-full threshold.
REQ-014 SHALL have port ae_threshold, input, address_size+1 bits: almost-empty threshold.
REQ-015 SHALL have port almost_full, output, 1 bit: fill_level >= af_threshold.
REQ-016 SHALL have port almost_empty, output, 1 bit: fill_level <= ae_threshold.
REQ-017 SHALL have port overflow, output, 1 bit: sticky, set by a write rejected while full.
REQ-018 SHALL have port underflow, output, 1 bit: sticky, set by a read rejected while empty.
REQ-019 SHALL have port clear_flags, input, 1 bit: synchronous clear of overflow and underflow.

Function
REQ-020 Write SHALL be accepted iff write_incr=1 and write_full=1'b0 at the edge; a write while full SHALL be rejected even if a read is accepted on the same edge.
REQ-021 Read SHALL be accepted iff read_incr=1 and read_empty=0 at the edge; a read while empty SHALL be rejected even if a write is accepted on the same edge.
REQ-022 Write and read pointers SHALL be address_size+1 bits, increment by 1 per accepted access, and wrap modulo 2**(address_size+1); the low address_size bits SHALL address memory.
REQ-023 fill_level SHALL equal write pointer minus read pointer (modulo 2**(address_size+1)); it SHALL change by +1, -1 or 0 (simultaneous accepted read and write) per edge.
REQ-024 write_full, read_empty, almost_full and almost_empty SHALL be combinational decodes of the registered fill_level and the current threshold inputs, with no added latency.
REQ-025 fwft=0: on an accepted read, read_data SHALL present the head word from the edge of acceptance on, and SHALL hold its value otherwise.
REQ-026 fwft=1: read_data SHALL present the head word whenever read_empty=0; an accepted read SHALL advance it to the next word at the same edge; read_data SHALL be don't-care while empty.
REQ-027 A write into an empty FIFO at edge N SHALL deassert read_empty after edge N, in both modes.
REQ-028 overflow/underflow SHALL set on the rejecting edge; if set and clear_flags occur on the same edge, set SHALL win.

Reset
REQ-029 While reset_n=0, both pointers SHALL be 0, fill_level=0, read_empty=1, write_full=0, overflow=0, underflow=0, and read_data=0; memory contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored words immediately; the first access after deassertion SHALL behave as on an empty FIFO.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the fwft mode constants (FIFO_STD=0, FIFO_FWFT=1) and the fill-level width function (address_size+1).
REQ-032 Storage SHALL be one sub-module, sync_fifo_mem: a depth x data_size array with a single clk write port and an asynchronous read port; pointers, flags and read register SHALL be in sync_fifo.

Verification
REQ-033 Defaults, fwft=0, reset, write 0x01..0x10 -> write_full=1, fill_level=16; 17th write -> overflow=1, contents unchanged.
REQ-034 Then read 16 -> read_data 0x01..0x10 in order, one cycle after each request; 17th read -> underflow=1; clear_flags -> both sticky flags 0.
REQ-035 fwft=1: one write of 0xA5 -> read_empty=0 and read_data=0xA5 on the next cycle without read_incr.
REQ-036 af_threshold=12, ae_threshold=3: fill 0->16 -> almost_empty=1 up to fill_level=3, almost_full=1 from fill_level=12.
REQ-037 Hold fill_level=8, assert write and read together for 40 cycles (pointer wrap) -> fill_level stays 8, data order preserved.
REQ-038 Assert reset_n=0 at fill_level=5 mid-burst -> read_empty=1, fill_level=0 immediately; the next write/read returns the new word.
